// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller.
//   ALU_OP_*   : 3-bit ALU SELECT codes; codes with bit 2 set are illegal
//   LAT_W      : width of the settle-time wait counter
//   state_e    : sequencer state encoding (idle / waiting on ALU / response pending)
//   op_is_legal: true for the four supported ALU operations
package alu_ctrl_pkg;

   localparam logic [2:0] ALU_OP_FWD = 3'b000;
   localparam logic [2:0] ALU_OP_ADD = 3'b001;
   localparam logic [2:0] ALU_OP_AND = 3'b010;
   localparam logic [2:0] ALU_OP_OR  = 3'b011;

   localparam int unsigned LAT_W = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   function automatic logic op_is_legal(input logic [2:0] op);
      return ~op[2];
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
//   valid0/valid1 : requester has an operation
//   last_grant    : requester granted most recently
//   enable        : arbitration allowed this cycle
//   grant         : winning requester id
//   grant_valid   : a grant is issued this cycle
module rr_arbiter2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   input  logic enable,
   output logic grant,
   output logic grant_valid
);

   always_comb begin
      grant_valid = enable & (valid0 | valid1);
      // On contention the requester that did not win last time goes first.
      if (valid0 && valid1) begin
         grant = ~last_grant;
      end else begin
         grant = valid1;
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: round-robin accepts an operation over a valid/ready
// handshake, drives the ALU, waits LATENCY cycles, then returns the captured result on a single
// response channel tagged with the requester id.
//   clk, rst_n                     : clock (rising edge), asynchronous active-low reset
//   req0_* / req1_*                : requester channels (valid, ready, op, a, b)
//   rsp_*                          : response channel (valid, ready, id, result, zero, err)
//   alu_data1/alu_data2/alu_select : ALU operand and select drive
//   alu_result/alu_zero            : ALU outputs, sampled after the settle time
//   busy                           : sequencer is not idle
module alu_share_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic [WIDTH-1:0] alu_data1,
   output logic [WIDTH-1:0] alu_data2,
   output logic [2:0]       alu_select,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             busy
);

   localparam logic [LAT_W-1:0] CntInit = LAT_W'(LATENCY - 1);

   state_e           state_q, state_d;
   logic [LAT_W-1:0] cnt_q;
   logic             last_grant_q;
   logic             rsp_id_q, rsp_zero_q, rsp_err_q;
   logic [WIDTH-1:0] rsp_result_q, alu_data1_q, alu_data2_q;
   logic [2:0]       alu_select_q;

   logic             grant, grant_valid, arb_enable;
   logic [2:0]       sel_op;
   logic [WIDTH-1:0] sel_a, sel_b;

   // Gated by rst_n so ready stays low while reset is held.
   assign arb_enable = (state_q == StIdle) & rst_n;

   rr_arbiter2 u_arb (
      .valid0      (req0_valid),
      .valid1      (req1_valid),
      .last_grant  (last_grant_q),
      .enable      (arb_enable),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   always_comb begin
      sel_op = grant ? req1_op : req0_op;
      sel_a  = grant ? req1_a  : req0_a;
      sel_b  = grant ? req1_b  : req0_b;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               // Illegal ops never touch the ALU and respond on the next cycle.
               state_d = op_is_legal(sel_op) ? StWait : StResp;
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      rsp_valid  = (state_q == StResp);
      busy       = (state_q != StIdle);
      req0_ready = grant_valid & ~grant;
      req1_ready = grant_valid & grant;
      rsp_id     = rsp_id_q;
      rsp_result = rsp_result_q;
      rsp_zero   = rsp_zero_q;
      rsp_err    = rsp_err_q;
      alu_data1  = alu_data1_q;
      alu_data2  = alu_data2_q;
      alu_select = alu_select_q;
   end

   // Datapath: operand latch, wait counter and response capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         alu_data1_q  <= '0;
         alu_data2_q  <= '0;
         alu_select_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_valid) begin
                  rsp_id_q     <= grant;
                  last_grant_q <= grant;
                  if (op_is_legal(sel_op)) begin
                     alu_select_q <= sel_op;
                     alu_data1_q  <= sel_a;
                     alu_data2_q  <= sel_b;
                     cnt_q        <= CntInit;
                  end else begin
                     rsp_result_q <= '0;
                     rsp_zero_q   <= 1'b0;
                     rsp_err_q    <= 1'b1;
                  end
               end
            end
            StWait: begin
               if (cnt_q == '0) begin
                  rsp_result_q <= alu_result;
                  rsp_zero_q   <= alu_zero;
                  rsp_err_q    <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with a behavioural ALU and a response
// scoreboard.
module tb_alu_share_ctrl;
   import alu_ctrl_pkg::*;

   localparam int unsigned WIDTH = 8;

   logic             clk, rst_n;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0]       req0_op, req1_op;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
   logic [WIDTH-1:0] rsp_result;
   logic [WIDTH-1:0] alu_data1, alu_data2, alu_result;
   logic [2:0]       alu_select;
   logic             alu_zero, busy;

   alu_share_ctrl #(.WIDTH(WIDTH), .LATENCY(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err),
      .alu_data1  (alu_data1),
      .alu_data2  (alu_data2),
      .alu_select (alu_select),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: ZERO always reflects the adder output.
   logic [WIDTH-1:0] alu_sum;
   always_comb begin
      alu_sum = alu_data1 + alu_data2;
      alu_zero = (alu_sum == '0);
      case (alu_select)
         ALU_OP_FWD: alu_result = alu_data1;
         ALU_OP_ADD: alu_result = alu_sum;
         ALU_OP_AND: alu_result = alu_data1 & alu_data2;
         ALU_OP_OR:  alu_result = alu_data1 | alu_data2;
         default:    alu_result = '0;
      endcase
   end

   typedef struct packed {
      logic             id;
      logic [WIDTH-1:0] result;
      logic             zero;
      logic             err;
   } rsp_t;

   rsp_t sb[$];
   rsp_t exp0, exp1;
   int   tests = 0;
   int   fails = 0;
   int   rsp_seen = 0;
   logic acc0, acc1;
   logic model_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1 after inputs are driven; samples at +2 and returns at next posedge+1.
   task automatic tick();
      rsp_t e;
      logic both;
      #1;
      both = req0_valid && req1_valid;
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (acc0) sb.push_back(exp0);
      if (acc1) sb.push_back(exp1);
      if (acc0 || acc1) begin
         if (both) check("rr_order", {31'd0, acc1}, {31'd0, ~model_last});
         model_last = acc1;
      end
      if (rsp_valid && rsp_ready) begin
         tests++;
         assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL rsp_unexpected: observed id %0h result %0h expected no response",
                   rsp_id, rsp_result);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
            check("rsp_result", {24'd0, rsp_result}, {24'd0, e.result});
            check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
            check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            rsp_seen++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input int max);
      int start;
      start = rsp_seen;
      for (int i = 0; i < max && rsp_seen == start; i++) tick();
      tests++;
      assert (rsp_seen != start) else begin
         fails++;
         $error("FAIL rsp_timeout: observed %0d responses expected %0d", rsp_seen, start + 1);
      end
   endtask

   initial begin
      int base;
      int grants;
      rst_n = 1'b0;
      {req0_valid, req1_valid, rsp_ready} = '0;
      {req0_op, req1_op} = '0;
      {req0_a, req0_b, req1_a, req1_b} = '0;
      exp0 = '0;
      exp1 = '0;
      model_last = 1'b1;
      #2;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      check("rst_ready0", {31'd0, req0_ready}, 32'd0);
      check("rst_ready1", {31'd0, req1_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_alu", {21'd0, alu_select, alu_data1, alu_data2}, 32'd0);
      check("rst_rsp", {21'd0, rsp_id, rsp_result, rsp_zero, rsp_err}, 32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 1: single ADD from requester 0
      rsp_ready = 1'b1;
      exp0 = '{1'b0, 8'h08, 1'b0, 1'b0};
      req0_op = ALU_OP_ADD; req0_a = 8'h05; req0_b = 8'h03; req0_valid = 1'b1;
      tick();
      check("t1_accept", {31'd0, acc0}, 32'd1);
      req0_valid = 1'b0;
      check("t1_select", {29'd0, alu_select}, 32'd1);
      check("t1_operands", {16'd0, alu_data1, alu_data2}, 32'h0503);
      check("t1_busy", {31'd0, busy}, 32'd1);
      check("t1_valid_early0", {31'd0, rsp_valid}, 32'd0);
      tick();
      check("t1_valid_early1", {31'd0, rsp_valid}, 32'd0);
      tick();
      check("t1_latency", {31'd0, rsp_valid}, 32'd1);
      tick();
      check("t1_valid_drop", {31'd0, rsp_valid}, 32'd0);
      check("t1_drained", sb.size(), 32'd0);

      // 2: both requesters continuously valid, grants must alternate
      base = rsp_seen;
      grants = 0;
      exp0 = '{1'b0, 8'h30, 1'b0, 1'b0};
      exp1 = '{1'b1, 8'hFF, 1'b0, 1'b0};
      req0_op = ALU_OP_AND; req0_a = 8'hF0; req0_b = 8'h3C; req0_valid = 1'b1;
      req1_op = ALU_OP_OR;  req1_a = 8'hF0; req1_b = 8'h0F; req1_valid = 1'b1;
      for (int i = 0; i < 40 && grants < 4; i++) begin
         tick();
         if (acc0 || acc1) grants++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("t2_grants", grants, 32'd4);
      wait_rsp(20);
      check("t2_responses", rsp_seen - base, 32'd4);

      // 3: ADD wrapping to zero sets ZERO
      exp1 = '{1'b1, 8'h00, 1'b1, 1'b0};
      req1_op = ALU_OP_ADD; req1_a = 8'hFF; req1_b = 8'h01; req1_valid = 1'b1;
      tick();
      check("t3_accept", {31'd0, acc1}, 32'd1);
      req1_valid = 1'b0;
      wait_rsp(20);

      // 4: illegal op responds after one cycle and leaves the ALU drive alone
      exp0 = '{1'b0, 8'h00, 1'b0, 1'b1};
      req0_op = 3'b101; req0_a = 8'hAA; req0_b = 8'h55; req0_valid = 1'b1;
      tick();
      check("t4_accept", {31'd0, acc0}, 32'd1);
      req0_valid = 1'b0;
      check("t4_latency", {31'd0, rsp_valid}, 32'd1);
      check("t4_alu_hold", {13'd0, alu_select, alu_data1, alu_data2}, {13'd0, 3'b001, 16'hFF01});
      wait_rsp(20);

      // 5: response stall blocks new grants
      rsp_ready = 1'b0;
      exp0 = '{1'b0, 8'h5A, 1'b0, 1'b0};
      req0_op = ALU_OP_FWD; req0_a = 8'h5A; req0_b = 8'h11; req0_valid = 1'b1;
      tick();
      check("t5_accept", {31'd0, acc0}, 32'd1);
      req0_valid = 1'b0;
      exp1 = '{1'b1, 8'h30, 1'b0, 1'b0};
      req1_op = ALU_OP_ADD; req1_a = 8'h10; req1_b = 8'h20; req1_valid = 1'b1;
      for (int i = 0; i < 10 && !rsp_valid; i++) tick();
      for (int i = 0; i < 10; i++) begin
         check("t5_stall_valid", {31'd0, rsp_valid}, 32'd1);
         check("t5_stall_rsp", {22'd0, rsp_id, rsp_result, rsp_err}, {22'd0, 1'b0, 8'h5A, 1'b0});
         check("t5_stall_ready1", {31'd0, req1_ready}, 32'd0);
         tick();
         check("t5_no_grant", {31'd0, acc1}, 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      tick();
      check("t5_req1_grant", {31'd0, acc1}, 32'd1);
      req1_valid = 1'b0;
      wait_rsp(20);

      // 6: reset mid-WAIT drops the operation; requester 0 wins first afterwards
      req0_op = ALU_OP_ADD; req0_a = 8'h01; req0_b = 8'h02; req0_valid = 1'b1;
      tick();
      check("t6_accept", {31'd0, acc0}, 32'd1);
      req0_valid = 1'b0;
      check("t6_in_wait", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_alu", {21'd0, alu_select, alu_data1, alu_data2}, 32'd0);
      check("t6_rst_rsp", {20'd0, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err}, 32'd0);
      sb.delete();
      model_last = 1'b1;
      @(posedge clk);
      #1;
      tick();
      tick();
      check("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
      rst_n = 1'b1;
      exp0 = '{1'b0, 8'h08, 1'b0, 1'b0};
      exp1 = '{1'b1, 8'hFF, 1'b0, 1'b0};
      req0_op = ALU_OP_ADD; req0_a = 8'h05; req0_b = 8'h03; req0_valid = 1'b1;
      req1_op = ALU_OP_OR;  req1_a = 8'hF0; req1_b = 8'h0F; req1_valid = 1'b1;
      tick();
      check("t6_first_grant0", {30'd0, acc0, acc1}, 32'd2);
      req0_valid = 1'b0;
      wait_rsp(20);
      tick();
      req1_valid = 1'b0;
      wait_rsp(20);
      check("t6_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
